d_stream_store: RTL and testbench
=================================

// Module: d_stream_store
// PURPOSE
//  Consumer end of the CGRA valid/ready data stream (din/din_v/din_r). Drains a
//  programmed number of tokens from an upstream D_FIFO output into the local
//  scratchpad write port, at base + k*stride. Sits between a PE output FIFO and
//  the bank SRAM; signals completion to the configuration controller.
// PARAMETERS
//  DATA_WIDTH  32  token / SRAM word width
//  ADDR_WIDTH  10  scratchpad word-address width (addresses wrap mod 2^ADDR_WIDTH)
//  CNT_WIDTH   16  width of token count and received counter
// PORTS
//  clock         in   1    single clock
//  reset         in   1    synchronous, active-high
//  io_start      in   1    start pulse; sampled only in IDLE
//  io_base       in   AW   first write address; latched on accepted start
//  io_stride     in   AW   address increment per token; latched on accepted start
//  io_count      in   CW   tokens to store; latched on accepted start
//  io_abort      in   1    terminate transfer; acted on only in RUN
//  io_din        in   DW   stream data
//  io_din_v      in   1    stream valid
//  io_din_r      out  1    stream ready
//  io_mem_we     out  1    registered SRAM write enable
//  io_mem_addr   out  AW   registered SRAM write address
//  io_mem_wdata  out  DW   registered SRAM write data
//  io_busy       out  1    high in RUN and DONE
//  io_done       out  1    one-cycle completion pulse
//  io_received   out  CW   tokens accepted in current/last transfer
// BEHAVIOUR
//  - Reset: state IDLE; din_r, mem_we, busy, done = 0; mem_addr, mem_wdata,
//    received = 0; latched base/stride/count = 0. Reset mid-transfer drops any
//    pending write (mem_we = 0 next cycle).
//  - FSM IDLE -> RUN on start with count != 0; IDLE -> DONE on start with count == 0
//    (done pulse, no writes). RUN -> DONE on the accept making received == count.
//    RUN -> IDLE on abort (no done pulse). DONE -> IDLE unconditionally (1 cycle).
//  - Accepted start clears received and loads next-address register with base.
//  - din_r = (state == RUN) && !io_abort, combinational from state; never depends
//    on din_v. Accept = din_v && din_r. No token accepted in IDLE/DONE/abort cycle.
//  - Accept at cycle t: mem_we=1, mem_addr=current address, mem_wdata=din at t+1
//    (latency 1); address += stride (mod 2^AW, silent wrap); received += 1.
//  - mem_we deasserts the cycle after a cycle with no accept; data/addr hold.
//  - Last accept at t: state DONE, done=1, din_r=0 at t+1, last write also at t+1;
//    IDLE at t+2. Back-to-back transfers: earliest next start sampled at t+2.
//  - start while busy ignored; start+abort together in IDLE: start taken.
//  - abort while RUN: write from previous cycle's accept still issues; received
//    holds the partial count.
//  - received saturates by construction at count; holds value in IDLE.
//  - Upstream may hold din_v with changing din only between accepts; module
//    captures din only on accept.
// STRUCTURE
//  - Shared package: state enum {IDLE, RUN, DONE}, default width constants.
//  - Single module; no sub-module. One FSM, address/count registers, one write
//    output register stage.
// TESTING
//  - base=0x010, stride=1, count=4, din_v always 1, data 0xA0..0xA3 -> writes
//    0x010..0x013 on 4 consecutive cycles, done pulse with last write, received=4.
//  - base=0x3FE, stride=3, count=3, AW=10 -> addresses 0x3FE, 0x001, 0x004.
//  - count=0 start -> done=1 next cycle, busy=1 for that cycle only, no mem_we.
//  - count=5, din_v toggling 1,0,1,1,0,1,1 -> exactly 5 writes, each 1 cycle after
//    its accept, din_r low from the cycle after 5th accept.
//  - count=8, abort after 3 accepts with din_v=1 -> 3 writes, no 4th accept, no
//    done, received=3, busy=0 next cycle; start during RUN ignored.
//  - reset asserted in cycle after 2nd accept of count=4 -> no further mem_we,
//    all outputs at reset values next cycle.

Source files
------------

// File: rtl/d_stream_store_pkg.sv
// -----------------------------------------------------------------------------
// d_stream_store_pkg
// Shared types and default widths for the stream-to-scratchpad store block.
//   state_e          : controller state (IDLE, RUN, DONE)
//   DEF_DATA_WIDTH   : token / SRAM word width
//   DEF_ADDR_WIDTH   : scratchpad word-address width
//   DEF_CNT_WIDTH    : token count / received counter width
// -----------------------------------------------------------------------------
package d_stream_store_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/d_stream_store_if.sv
// -----------------------------------------------------------------------------
// d_stream_store_if
// Valid/ready data stream between a producer (e.g. a PE output FIFO) and a
// consumer such as d_stream_store.
//   din    : stream data, driven by the producer
//   din_v  : stream valid, driven by the producer
//   din_r  : stream ready, driven by the consumer
// A token moves on every clock edge where din_v and din_r are both high.
// -----------------------------------------------------------------------------
interface d_stream_store_if
  import d_stream_store_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] din;
  logic                  din_v;
  logic                  din_r;

  modport master (output din, output din_v, input  din_r);
  modport slave  (input  din, input  din_v, output din_r);

endinterface

// File: rtl/d_stream_store.sv
// -----------------------------------------------------------------------------
// d_stream_store
// Drains a programmed number of tokens from a valid/ready stream into the
// scratchpad write port at base + k*stride, then pulses done.
// Ports:
//   clock, reset   : single clock, synchronous active-high reset
//   io_start       : start pulse, honoured only in IDLE
//   io_base        : first write address (latched on accepted start)
//   io_stride      : address increment per token (latched on accepted start)
//   io_count       : number of tokens to store (latched on accepted start)
//   io_abort       : terminate the transfer, honoured only in RUN
//   io             : stream slave (din, din_v in; din_r out)
//   io_mem_we      : registered SRAM write enable
//   io_mem_addr    : registered SRAM write address
//   io_mem_wdata   : registered SRAM write data
//   io_busy        : high in RUN and DONE
//   io_done        : one-cycle completion pulse
//   io_received    : tokens accepted in the current / last transfer
// -----------------------------------------------------------------------------
module d_stream_store
  import d_stream_store_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic [ADDR_WIDTH-1:0] io_base,
  input  logic [ADDR_WIDTH-1:0] io_stride,
  input  logic [CNT_WIDTH-1:0]  io_count,
  input  logic                  io_abort,
  d_stream_store_if.slave       io,
  output logic                  io_mem_we,
  output logic [ADDR_WIDTH-1:0] io_mem_addr,
  output logic [DATA_WIDTH-1:0] io_mem_wdata,
  output logic                  io_busy,
  output logic                  io_done,
  output logic [CNT_WIDTH-1:0]  io_received
);

  state_e                state;
  logic [ADDR_WIDTH-1:0] addr_q;    // address for the next accepted token
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  accept;
  logic                  last_accept;

  // NOTE: continuous assigns for combinational decode; every output has a
  // value on every path, so no storage (latch) can be inferred.
  // Ready depends only on state and abort, never on din_v, so the upstream
  // FIFO cannot form a combinational loop through this block.
  assign io.din_r      = (state == RUN) && !io_abort;
  assign accept        = io.din_v && io.din_r;
  assign last_accept   = accept && ((io_received + CNT_WIDTH'(1)) == count_q);

  // Pure decodes of the state register, so they are glitch-free and carry no
  // input-to-output path.
  assign io_busy = (state != IDLE);
  assign io_done = (state == DONE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      count_q      <= '0;
      io_received  <= '0;
      io_mem_we    <= 1'b0;
      io_mem_addr  <= '0;
      io_mem_wdata <= '0;
    end else begin
      // One output register stage: the write issues the cycle after the accept.
      // Address and data hold when there is no accept.
      io_mem_we <= accept;
      if (accept) begin
        io_mem_addr  <= addr_q;
        io_mem_wdata <= io.din;
        addr_q       <= addr_q + stride_q;  // wraps silently mod 2^ADDR_WIDTH
        io_received  <= io_received + CNT_WIDTH'(1);
      end

      // accept is never true outside RUN, so the IDLE loads below never
      // collide with the accept updates above.
      case (state)
        IDLE: begin
          if (io_start) begin
            addr_q      <= io_base;
            stride_q    <= io_stride;
            count_q     <= io_count;
            io_received <= '0;
            state       <= (io_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (io_abort) begin
            state <= IDLE;
          end else if (last_accept) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_stream_store.sv
// -----------------------------------------------------------------------------
// tb_d_stream_store
// Directed bench for d_stream_store. Stimulus pushes each expected SRAM write
// (address, data, cycle) into a queue; a monitor on the falling edge pops and
// compares whenever the DUT asserts io_mem_we. Status outputs are checked
// directly by the stimulus process against hand-computed values.
// -----------------------------------------------------------------------------
module tb_d_stream_store;
  import d_stream_store_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int CW = DEF_CNT_WIDTH;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_start;
  logic [AW-1:0] io_base;
  logic [AW-1:0] io_stride;
  logic [CW-1:0] io_count;
  logic          io_abort;
  logic          io_mem_we;
  logic [AW-1:0] io_mem_addr;
  logic [DW-1:0] io_mem_wdata;
  logic          io_busy;
  logic          io_done;
  logic [CW-1:0] io_received;

  d_stream_store_if #(.DATA_WIDTH(DW)) s_if ();

  d_stream_store #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_base     (io_base),
    .io_stride   (io_stride),
    .io_count    (io_count),
    .io_abort    (io_abort),
    .io          (s_if),
    .io_mem_we   (io_mem_we),
    .io_mem_addr (io_mem_addr),
    .io_mem_wdata(io_mem_wdata),
    .io_busy     (io_busy),
    .io_done     (io_done),
    .io_received (io_received)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write,
  // including the cycle it was due in.
  always @(negedge clock) begin
    if (io_mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                 io_mem_addr, io_mem_wdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr",  64'(io_mem_addr),  64'(mon_e.addr));
        check("wr_data",  64'(io_mem_wdata), 64'(mon_e.data));
        check("wr_cycle", 64'(cyc),          64'(mon_e.cyc));
      end
    end
  end

  // One stream cycle: present (v, d), check ready mid-cycle, and record the
  // write that must appear one cycle after an accept.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic exp_r,
                       input logic [AW-1:0] exp_addr);
    wr_t e;
    s_if.din_v = v;
    s_if.din   = d;
    @(negedge clock);
    check("din_r", 64'(s_if.din_r), 64'(exp_r));
    if (v && exp_r) begin
      e.addr = exp_addr;
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  // Start pulse; config inputs are scrambled afterwards to prove they were latched.
  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] c);
    io_start  = 1'b1;
    io_base   = b;
    io_stride = s;
    io_count  = c;
    @(posedge clock);
    #1;
    io_start  = 1'b0;
    io_base   = 10'h155;
    io_stride = 10'h0AA;
    io_count  = 16'h00FF;
  endtask

  task automatic status(input string tag, input logic busy, input logic done, input logic [CW-1:0] rcv);
    check({tag, "_busy"},     64'(io_busy),     64'(busy));
    check({tag, "_done"},     64'(io_done),     64'(done));
    check({tag, "_received"}, 64'(io_received), 64'(rcv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    io_start   = 1'b0;
    io_base    = '0;
    io_stride  = '0;
    io_count   = '0;
    io_abort   = 1'b0;
    s_if.din_v = 1'b0;
    s_if.din   = '0;
    repeat (2) @(posedge clock);
    #1;
    status("reset", 1'b0, 1'b0, 16'd0);
    check("reset_we",    64'(io_mem_we),    64'd0);
    check("reset_addr",  64'(io_mem_addr),  64'd0);
    check("reset_wdata", 64'(io_mem_wdata), 64'd0);
    check("reset_din_r", 64'(s_if.din_r),   64'd0);
    reset = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, '0);  // idle: no accept

    // Basic 4-token transfer, stride 1.
    start_xfer(10'h010, 10'd1, 16'd4);
    status("t1_start", 1'b1, 1'b0, 16'd0);
    drive(1'b1, 32'h0000_00A0, 1'b1, 10'h010);
    drive(1'b1, 32'h0000_00A1, 1'b1, 10'h011);
    drive(1'b1, 32'h0000_00A2, 1'b1, 10'h012);
    drive(1'b1, 32'h0000_00A3, 1'b1, 10'h013);
    status("t1_last", 1'b1, 1'b1, 16'd4);
    drive(1'b0, 32'h0, 1'b0, '0);
    status("t1_idle", 1'b0, 1'b0, 16'd4);

    // Address wrap: 0x3FE + 3 -> 0x001 -> 0x004.
    start_xfer(10'h3FE, 10'd3, 16'd3);
    drive(1'b1, 32'h0000_00C0, 1'b1, 10'h3FE);
    drive(1'b1, 32'h0000_00C1, 1'b1, 10'h001);
    drive(1'b1, 32'h0000_00C2, 1'b1, 10'h004);
    status("t2_last", 1'b1, 1'b1, 16'd3);
    drive(1'b0, 32'h0, 1'b0, '0);

    // Zero-count start: done next cycle, busy for that cycle only, no writes.
    start_xfer(10'h050, 10'd1, 16'd0);
    status("t3_done", 1'b1, 1'b1, 16'd0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, '0);
    status("t3_idle", 1'b0, 1'b0, 16'd0);
    drive(1'b0, 32'h0, 1'b0, '0);

    // Valid toggling 1,0,1,1,0,1,1 with count 5, stride 4.
    start_xfer(10'h020, 10'd4, 16'd5);
    drive(1'b1, 32'h0000_00B0, 1'b1, 10'h020);
    drive(1'b0, 32'h0000_00B1, 1'b1, '0);
    drive(1'b1, 32'h0000_00B1, 1'b1, 10'h024);
    drive(1'b1, 32'h0000_00B2, 1'b1, 10'h028);
    drive(1'b0, 32'h0000_00B3, 1'b1, '0);
    drive(1'b1, 32'h0000_00B3, 1'b1, 10'h02C);
    drive(1'b1, 32'h0000_00B4, 1'b1, 10'h030);
    status("t4_last", 1'b1, 1'b1, 16'd5);
    drive(1'b1, 32'h0000_00B5, 1'b0, '0);
    status("t4_idle", 1'b0, 1'b0, 16'd5);

    // Abort after 3 accepts of 8; a start during RUN must be ignored.
    start_xfer(10'h100, 10'd2, 16'd8);
    drive(1'b1, 32'h0000_00D0, 1'b1, 10'h100);
    io_start = 1'b1;
    io_base  = 10'h3C0;
    io_count = 16'd1;
    drive(1'b1, 32'h0000_00D1, 1'b1, 10'h102);
    io_start = 1'b0;
    status("t5_run", 1'b1, 1'b0, 16'd2);
    drive(1'b1, 32'h0000_00D2, 1'b1, 10'h104);
    status("t5_pre_abort", 1'b1, 1'b0, 16'd3);
    io_abort = 1'b1;
    drive(1'b1, 32'h0000_00D3, 1'b0, '0);
    io_abort = 1'b0;
    status("t5_aborted", 1'b0, 1'b0, 16'd3);
    drive(1'b1, 32'h0000_00D4, 1'b0, '0);
    status("t5_idle", 1'b0, 1'b0, 16'd3);

    // Start and abort together in IDLE: start is taken.
    s_if.din_v = 1'b0;
    io_abort   = 1'b1;
    start_xfer(10'h1F0, 10'd1, 16'd1);
    io_abort   = 1'b0;
    status("t5b_start", 1'b1, 1'b0, 16'd0);
    drive(1'b1, 32'h0000_00E0, 1'b1, 10'h1F0);
    status("t5b_last", 1'b1, 1'b1, 16'd1);
    drive(1'b0, 32'h0, 1'b0, '0);

    // Reset in the cycle after the 2nd accept of 4: pending write still shows,
    // nothing after, all outputs at reset values.
    start_xfer(10'h200, 10'd1, 16'd4);
    drive(1'b1, 32'h0000_00F0, 1'b1, 10'h200);
    drive(1'b1, 32'h0000_00F1, 1'b1, 10'h201);
    reset      = 1'b1;
    s_if.din_v = 1'b1;
    s_if.din   = 32'h0000_00F2;
    @(posedge clock);
    #1;
    reset = 1'b0;
    status("t6_reset", 1'b0, 1'b0, 16'd0);
    check("t6_we",    64'(io_mem_we),    64'd0);
    check("t6_addr",  64'(io_mem_addr),  64'd0);
    check("t6_wdata", 64'(io_mem_wdata), 64'd0);
    check("t6_din_r", 64'(s_if.din_r),   64'd0);
    drive(1'b1, 32'h0000_00F3, 1'b0, '0);
    drive(1'b0, 32'h0, 1'b0, '0);

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
